feistel_decrypt_iter: RTL and testbench
=======================================

Name: feistel_decrypt_iter

Overview:
- Iterative DES decryption engine: the inverse of the team's combinational 16-round Feistel encryption network.
- Performs one Feistel round per clock, reusing the existing round, initial_permutation and inv_permutation modules.
- Subkeys are applied in reverse order (subkey_15 first).
- Sits between the ciphertext source and the plaintext consumer, with a valid/ready handshake on each side.

Parameters:
none (16 rounds and 48-bit subkeys are fixed by the encryption core)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  cphrtxt valid
in_ready  output  1  block can accept ciphertext
cphrtxt  input  64  ciphertext block
subkey_0 .. subkey_15  input  48 each  key schedule, same indexing as the encryption core; must stay stable from acceptance until the output handshake
out_valid  output  1  plntxt valid
out_ready  input  1  consumer accepts plntxt
plntxt  output  64  recovered plaintext, registered
busy  output  1  high in ROUND or DONE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async assert, any state, including mid-decryption): state=IDLE, cnt=0, round register=0, plntxt=0, out_valid=0, busy=0, in_ready=1. Any in-flight block is discarded with no output.
- Encryption convention being inverted:
  - encryption output is C = IPinv({L16,R16}), with no standard pre-output swap.
  - each round computes out_left = in_right; out_right = in_left ^ f(in_right, k).
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T0: let {A,B} = IP(cphrtxt). Load the round register with {B,A} (halves swapped). Set cnt=15. Go to ROUND.
- ROUND:
  - in_ready=0.
  - Each edge: round register <= round(in_left=reg[63:32], in_right=reg[31:0], subkey=subkey_[cnt]); then cnt <= cnt-1.
  - Edge where cnt==0: the round output {X,Y} is swapped to {Y,X}. Load plntxt <= IPinv({Y,X}), set out_valid=1, go to DONE.
  - Net effect: 16 rounds at edges T0+1..T0+16 with subkeys 15,14,...,0.
- DONE:
  - out_valid=1; plntxt held stable.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - plntxt keeps its last value until the next completion.
- Timing:
  - Latency: out_valid is first high in the cycle after edge T0+16 (16 cycles after acceptance).
  - Minimum spacing between accepts is 18 cycles with out_ready tied high.
- in_ready is combinational (state==IDLE). It does not depend on out_ready, and there is no overlap of blocks.
- in_valid while not IDLE is ignored. cphrtxt is sampled only at the accept edge.
- cnt is 4 bits. 0 is its terminal value; it never wraps in ROUND.
- Subkey mux is combinational from cnt. Changing subkeys during ROUND/DONE is a protocol violation; the result is undefined but the FSM still completes.
- The block is fully synchronous apart from the reset; there are no combinational paths from in_* to out_*.

Test Plan:
- Round trip, zero keys: all subkeys=0. Encrypt P=64'h0123456789ABCDEF with the existing encryption network to get C. Present C -> out_valid rises exactly 16 cycles after accept with plntxt=64'h0123456789ABCDEF; in_ready=0 throughout.
- Round trip, real schedule: DES key schedule from key 64'h133457799BBCDFF1; P=64'h0123456789ABCDEF, then 64'hFFFFFFFFFFFFFFFF, then 64'h0 -> each plntxt equals its P. Use subkey_i distinct values to prove the reversed order (swapping two subkeys must break the round trip).
- Output backpressure: hold out_ready=0 for 10 cycles after completion -> out_valid and plntxt stable, in_ready=0, new in_valid ignored. Release -> handshake in one cycle, in_ready=1 next cycle.
- Back-to-back: in_valid held high with 3 ciphertexts and out_ready=1 -> accepts exactly 18 cycles apart, outputs in order, no drops.
- Reset mid-operation: assert rst_n=0 asynchronously at round 7 -> out_valid=0, plntxt=0, in_ready=1 immediately. After release, a new block decrypts correctly with standard 16-cycle latency.
- Ignored input: pulse in_valid with a different cphrtxt during ROUND -> result unchanged, matches the originally accepted block.

Source files
------------

// File: rtl/feistel_decrypt_iter.sv
// Iterative DES decryption engine: one Feistel round per clock with subkeys 15 down to 0.
// The block is accepted 16 cycles before out_valid. One block is in flight at a time, and the result is held until out_ready.

module initial_permutation (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  // Table entries are 1-based bit numbers counted from the MSB.
  always_comb begin
    dout = '0;
    for (int i = 0; i < 64; i++) dout[6'(63 - i)] = din[6'(64 - IP_T[i])];
  end
endmodule

module inv_permutation (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  always_comb begin
    dout = '0;
    for (int i = 0; i < 64; i++) dout[6'(63 - i)] = din[6'(64 - FP_T[i])];
  end
endmodule

module round (
  input  logic [31:0] in_left,
  input  logic [31:0] in_right,
  input  logic [47:0] subkey,
  output logic [31:0] out_left,
  output logic [31:0] out_right
);
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  // Each S-box is 64 nibbles in row-major order (row = outer bits, col = inner bits).
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic [47:0] ex;
  logic [47:0] xk;
  logic [5:0]  six;
  logic [5:0]  sidx;
  logic [31:0] sout;
  logic [31:0] fout;

  always_comb begin
    ex   = '0;
    sout = '0;
    fout = '0;
    six  = '0;
    sidx = '0;
    for (int i = 0; i < 48; i++) ex[6'(47 - i)] = in_right[5'(32 - E_T[i])];
    for (int j = 0; j < 8; j++) begin
      six  = xk[6'(47 - 6 * j) -: 6];
      sidx = {six[5], six[0], six[4:1]};
      sout[5'(31 - 4 * j) -: 4] = SBOX[j][8'(255 - 4 * int'(sidx)) -: 4];
    end
    for (int i = 0; i < 32; i++) fout[5'(31 - i)] = sout[5'(32 - P_T[i])];
  end

  assign xk        = ex ^ subkey;
  assign out_left  = in_right;
  assign out_right = in_left ^ fout;
endmodule

module feistel_decrypt_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cphrtxt,
  input  logic [47:0] subkey_0,
  input  logic [47:0] subkey_1,
  input  logic [47:0] subkey_2,
  input  logic [47:0] subkey_3,
  input  logic [47:0] subkey_4,
  input  logic [47:0] subkey_5,
  input  logic [47:0] subkey_6,
  input  logic [47:0] subkey_7,
  input  logic [47:0] subkey_8,
  input  logic [47:0] subkey_9,
  input  logic [47:0] subkey_10,
  input  logic [47:0] subkey_11,
  input  logic [47:0] subkey_12,
  input  logic [47:0] subkey_13,
  input  logic [47:0] subkey_14,
  input  logic [47:0] subkey_15,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plntxt,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [63:0] rnd_q;
  logic [63:0] ip_dat;
  logic [63:0] fp_dat;
  logic [31:0] rnd_l, rnd_r;
  logic [47:0] key_sel;

  always_comb begin
    key_sel = subkey_0;
    case (cnt)
      4'd1:  key_sel = subkey_1;
      4'd2:  key_sel = subkey_2;
      4'd3:  key_sel = subkey_3;
      4'd4:  key_sel = subkey_4;
      4'd5:  key_sel = subkey_5;
      4'd6:  key_sel = subkey_6;
      4'd7:  key_sel = subkey_7;
      4'd8:  key_sel = subkey_8;
      4'd9:  key_sel = subkey_9;
      4'd10: key_sel = subkey_10;
      4'd11: key_sel = subkey_11;
      4'd12: key_sel = subkey_12;
      4'd13: key_sel = subkey_13;
      4'd14: key_sel = subkey_14;
      4'd15: key_sel = subkey_15;
      default: key_sel = subkey_0;
    endcase
  end

  initial_permutation u_ip (.din(cphrtxt), .dout(ip_dat));

  round u_round (
    .in_left  (rnd_q[63:32]),
    .in_right (rnd_q[31:0]),
    .subkey   (key_sel),
    .out_left (rnd_l),
    .out_right(rnd_r)
  );

  // The final round output is half-swapped before the inverse permutation.
  inv_permutation u_fp (.din({rnd_r, rnd_l}), .dout(fp_dat));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ROUND;
      end
      ROUND: if (cnt == 4'd0) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 4'd0;
      rnd_q  <= '0;
      plntxt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // The ciphertext carries {L16,R16} with no pre-output swap; start from {R16,L16}.
          rnd_q <= {ip_dat[31:0], ip_dat[63:32]};
          cnt   <= 4'd15;
        end
        ROUND: begin
          rnd_q <= {rnd_l, rnd_r};
          if (cnt == 4'd0) plntxt <= fp_dat;
          else             cnt    <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_feistel_decrypt_iter.sv
// Round-trip bench: a behavioural DES encryption model produces ciphertexts,
// and the decryptor must return the original plaintexts with the documented timing.
module tb_feistel_decrypt_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] cphrtxt = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] plntxt;
  logic [47:0] sk [16];
  logic [47:0] ks [16];
  int n_pass = 0, n_total = 0, n_fail = 0;

  always #5 clk = ~clk;

  feistel_decrypt_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .cphrtxt(cphrtxt),
    .subkey_0(sk[0]), .subkey_1(sk[1]), .subkey_2(sk[2]), .subkey_3(sk[3]),
    .subkey_4(sk[4]), .subkey_5(sk[5]), .subkey_6(sk[6]), .subkey_7(sk[7]),
    .subkey_8(sk[8]), .subkey_9(sk[9]), .subkey_10(sk[10]), .subkey_11(sk[11]),
    .subkey_12(sk[12]), .subkey_13(sk[13]), .subkey_14(sk[14]), .subkey_15(sk[15]),
    .out_valid(out_valid), .out_ready(out_ready), .plntxt(plntxt), .busy(busy)
  );

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Bit pos (1-based from the MSB) of a w-bit value held in the low bits of src.
  function automatic logic [63:0] pick(input logic [63:0] src, input int w, input int pos);
    return (src >> (w - pos)) & 64'd1;
  endfunction

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] x, s, o;
    int b, row, col;
    x = '0;
    for (int i = 0; i < 48; i++) x = (x << 1) | pick({32'd0, r}, 32, E_T[i]);
    x = x ^ {16'd0, k};
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b   = int'((x >> (42 - 6 * j)) & 64'd63);
      row = (b >> 5) * 2 + (b & 1);
      col = (b >> 1) & 15;
      s   = (s << 4) | 64'((SB[j] >> (4 * (63 - (row * 16 + col)))) & 256'hF);
    end
    o = '0;
    for (int i = 0; i < 32; i++) o = (o << 1) | pick(s, 32, P_T[i]);
    return o[31:0];
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] y);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o = o | (((y >> (63 - i)) & 64'd1) << (64 - IP_T[i]));
    return o;
  endfunction

  // Encryption convention: C = IPinv({L16,R16}), subkey i used in round i.
  function automatic logic [63:0] enc(input logic [63:0] p);
    logic [63:0] v;
    logic [31:0] l, r, t;
    v = '0;
    for (int i = 0; i < 64; i++) v = (v << 1) | pick(p, 64, IP_T[i]);
    l = v[63:32];
    r = v[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_model(r, ks[i]);
      l = t;
    end
    return ip_inv({l, r});
  endfunction

  task automatic key_sched(input logic [63:0] key);
    logic [63:0] cd, k;
    logic [27:0] c, d;
    cd = '0;
    for (int i = 0; i < 56; i++) cd = (cd << 1) | pick(key, 64, PC1_T[i]);
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      k = '0;
      for (int j = 0; j < 48; j++) k = (k << 1) | pick({8'd0, c, d}, 56, PC2_T[j]);
      ks[r] = k[47:0];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] c);
    int w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    cphrtxt  = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts clock edges since the accept edge until out_valid is seen.
  task automatic wait_out(input int start, output int lat, output int bad);
    lat = start;
    bad = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic roundtrip(input logic [63:0] p, input string tag);
    int lat, bad;
    send(enc(p));
    wait_out(0, lat, bad);
    chk({tag, "_lat"}, 64'(lat), 64'd16);
    chk({tag, "_busy"}, 64'(bad), 64'd0);
    chk({tag, "_pt"}, plntxt, p);
    @(negedge clk);
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] p, c;
    logic [63:0] bp [3];
    logic [63:0] bc [3];
    int acc [3];
    int idx, got, cyc, lat, bad, bp_bad;

    for (int i = 0; i < 16; i++) begin
      ks[i] = '0;
      sk[i] = '0;
    end
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_plntxt", plntxt, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    roundtrip(64'h0123456789ABCDEF, "zero_keys");

    key_sched(64'h133457799BBCDFF1);
    for (int i = 0; i < 16; i++) sk[i] = ks[i];
    roundtrip(64'h0123456789ABCDEF, "des_0123");
    roundtrip(64'hFFFFFFFFFFFFFFFF, "des_ones");
    roundtrip(64'h0000000000000000, "des_zero");
    for (int i = 0; i < 3; i++) roundtrip({$urandom, $urandom}, "des_rand");

    // Swapping two subkeys must break the round trip.
    p = {$urandom, $urandom};
    c = enc(p);
    sk[3] = ks[9];
    sk[9] = ks[3];
    send(c);
    wait_out(0, lat, bad);
    chk("swap_breaks", 64'(plntxt != p), 64'd1);
    @(negedge clk);
    sk[3] = ks[3];
    sk[9] = ks[9];

    // Output backpressure with ignored input traffic.
    p = {$urandom, $urandom};
    c = enc(p);
    out_ready = 1'b0;
    send(c);
    wait_out(0, lat, bad);
    chk("bp_lat", 64'(lat), 64'd16);
    chk("bp_pt", plntxt, p);
    bp_bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      cphrtxt  = ~c;
      @(negedge clk);
      if (out_valid !== 1'b1 || plntxt !== p || in_ready !== 1'b0) bp_bad++;
    end
    chk("bp_stable", 64'(bp_bad), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready), 64'd1);

    // Back-to-back with in_valid held high.
    for (int i = 0; i < 3; i++) begin
      bp[i] = {$urandom, $urandom};
      bc[i] = enc(bp[i]);
      acc[i] = 0;
    end
    idx = 0;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 200) begin
      if (out_valid === 1'b1) begin
        chk("b2b_data", plntxt, bp[got]);
        got++;
      end
      if (in_ready === 1'b1) begin
        if (idx < 3) begin
          in_valid = 1'b1;
          cphrtxt  = bc[idx];
          acc[idx] = cyc;
          idx++;
        end else in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_count", 64'(got), 64'd3);
    chk("b2b_gap01", 64'(acc[1] - acc[0]), 64'd18);
    chk("b2b_gap12", 64'(acc[2] - acc[1]), 64'd18);

    // Asynchronous reset in the middle of the rounds.
    send(enc({$urandom, $urandom}));
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_plntxt", plntxt, 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    roundtrip({$urandom, $urandom}, "post_rst");

    // A new ciphertext offered during ROUND must not disturb the block in flight.
    p = {$urandom, $urandom};
    c = enc(p);
    send(c);
    repeat (4) @(negedge clk);
    in_valid = 1'b1;
    cphrtxt  = ~c;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(5, lat, bad);
    chk("ign_lat", 64'(lat), 64'd16);
    chk("ign_busy", 64'(bad), 64'd0);
    chk("ign_pt", plntxt, p);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
